// File: rtl/ssd1963_pkg.sv
// Shared constants, state encoding and byte-select helpers for the SSD1963 window sequencer.
// SSD1963_SEQ_RGB565_EN selects 2-byte RGB565 pixels; otherwise pixels are 3 bytes {R,G,B}.
package ssd1963_pkg;

  localparam logic [7:0] CMD_SET_COL  = 8'h2A;
  localparam logic [7:0] CMD_SET_PAGE = 8'h2B;
  localparam logic [7:0] CMD_WR_MEM   = 8'h2C;

`ifdef SSD1963_SEQ_RGB565_EN
  localparam int BYTES_PER_PIX = 2;
`else
  localparam int BYTES_PER_PIX = 3;
`endif

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_PIX - 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CMD_COL  = 4'd1,
    ST_ARG_COL  = 4'd2,
    ST_CMD_PAGE = 4'd3,
    ST_ARG_PAGE = 4'd4,
    ST_CMD_WR   = 4'd5,
    ST_PIX      = 4'd6,
    ST_DONE     = 4'd7
  } state_e;

  // Byte idx of a pixel, MSB byte first.
  function automatic logic [7:0] pix_byte(input logic [23:0] d, input logic [1:0] idx);
`ifdef SSD1963_SEQ_RGB565_EN
    pix_byte = (idx == 2'd0) ? d[15:8] : d[7:0];
`else
    case (idx)
      2'd0:    pix_byte = d[23:16];
      2'd1:    pix_byte = d[15:8];
      default: pix_byte = d[7:0];
    endcase
`endif
  endfunction

  // Argument byte idx of a start/end pair: start MSB, start LSB, end MSB, end LSB.
  function automatic logic [7:0] arg_byte(input logic [15:0] s, input logic [15:0] e,
                                          input logic [1:0] idx);
    case (idx)
      2'd0:    arg_byte = s[15:8];
      2'd1:    arg_byte = s[7:0];
      2'd2:    arg_byte = e[15:8];
      default: arg_byte = e[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ssd1963_pix_ser.sv
// One-pixel holding register that serializes pixels into display bus bytes.
// Byte count per pixel follows SSD1963_SEQ_RGB565_EN through ssd1963_pkg.
module ssd1963_pix_ser
  import ssd1963_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [23:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  logic        full_q, full_d;
  logic [23:0] data_q, data_d;
  logic [1:0]  idx_q, idx_d;
  logic        bypass, fire, last_fire, take;

  // An empty register forwards the first byte straight from the source so PIX has no bubble.
  always_comb begin
    bypass    = en && in_valid && !full_q;
    out_valid = full_q || bypass;
    out_data  = 8'h00;
    if (full_q) begin
      out_data = pix_byte(data_q, idx_q);
    end else if (bypass) begin
      out_data = pix_byte(in_data, 2'd0);
    end
    fire      = out_valid && out_ready;
    last_fire = full_q && fire && (idx_q == LAST_IDX);
    in_ready  = en && (!full_q || last_fire);
    take      = in_valid && in_ready;
    out_last  = last_fire;
  end

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    idx_d  = idx_q;
    if (clr) begin
      full_d = 1'b0;
      data_d = 24'h0;
      idx_d  = 2'd0;
    end else if (take) begin
      full_d = 1'b1;
      data_d = in_data;
      idx_d  = (!full_q && fire) ? 2'd1 : 2'd0;
    end else if (last_fire) begin
      full_d = 1'b0;
      idx_d  = 2'd0;
    end else if (full_q && fire) begin
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= 24'h0;
      idx_q  <= 2'd0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/ssd1963_win_seq.sv
// SSD1963 window-write sequencer: column/page address setup, memory-write command, pixel stream.
// Pixel width is 24-bit by default, RGB565 when SSD1963_SEQ_RGB565_EN is defined.
//
// Handshakes: a byte moves on out_valid && out_ready, a pixel on pix_valid && pix_ready;
// out_data/out_dc hold while out_valid && !out_ready, and abort withdraws out_valid at once.
module ssd1963_win_seq
  import ssd1963_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] sx,
  input  logic [15:0] sy,
  input  logic [15:0] sw,
  input  logic [15:0] sh,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  out_data,
  output logic        out_dc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [3:0]  dbg_state
);

  state_e      state_q, state_d;
  logic [1:0]  arg_idx_q, arg_idx_d;
  logic [15:0] sx_q, sx_d, sy_q, sy_d, ec_q, ec_d, ep_q, ep_d;
  logic [31:0] rem_q, rem_d;
  logic        done_q, done_d;

  logic        accept, xfer_ok;
  logic        ser_en, ser_in_ready, ser_valid, ser_last, ser_take;
  logic [7:0]  ser_data;
  logic        raw_valid, raw_dc;
  logic [7:0]  raw_data;

  assign accept   = start && !abort && (state_q == ST_IDLE) && !done_q;
  assign xfer_ok  = out_ready && !abort;
  assign ser_en   = (state_q == ST_PIX) && (rem_q != 32'd0) && !abort;
  assign ser_take = pix_valid && ser_in_ready;

  ssd1963_pix_ser u_ser (
    .clk       (clk),
    .rst_n     (reset_n),
    .clr       (abort),
    .en        (ser_en),
    .in_data   (pix_data),
    .in_valid  (pix_valid),
    .in_ready  (ser_in_ready),
    .out_data  (ser_data),
    .out_valid (ser_valid),
    .out_ready (xfer_ok),
    .out_last  (ser_last)
  );

  always_comb begin
    state_d   = state_q;
    arg_idx_d = arg_idx_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    ec_d      = ec_q;
    ep_d      = ep_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    raw_valid = 1'b0;
    raw_dc    = 1'b0;
    raw_data  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sx_d      = sx;
          sy_d      = sy;
          ec_d      = sx + sw - 16'd1;
          ep_d      = sy + sh - 16'd1;
          rem_d     = {16'h0, sw} * {16'h0, sh};
          arg_idx_d = 2'd0;
          state_d   = (sw == 16'd0 || sh == 16'd0) ? ST_DONE : ST_CMD_COL;
        end
      end
      ST_CMD_COL: begin
        raw_valid = 1'b1;
        raw_data  = CMD_SET_COL;
        if (xfer_ok) state_d = ST_ARG_COL;
      end
      ST_ARG_COL: begin
        raw_valid = 1'b1;
        raw_dc    = 1'b1;
        raw_data  = arg_byte(sx_q, ec_q, arg_idx_q);
        if (xfer_ok) begin
          arg_idx_d = arg_idx_q + 2'd1;
          if (arg_idx_q == 2'd3) state_d = ST_CMD_PAGE;
        end
      end
      ST_CMD_PAGE: begin
        raw_valid = 1'b1;
        raw_data  = CMD_SET_PAGE;
        if (xfer_ok) state_d = ST_ARG_PAGE;
      end
      ST_ARG_PAGE: begin
        raw_valid = 1'b1;
        raw_dc    = 1'b1;
        raw_data  = arg_byte(sy_q, ep_q, arg_idx_q);
        if (xfer_ok) begin
          arg_idx_d = arg_idx_q + 2'd1;
          if (arg_idx_q == 2'd3) state_d = ST_CMD_WR;
        end
      end
      ST_CMD_WR: begin
        raw_valid = 1'b1;
        raw_data  = CMD_WR_MEM;
        if (xfer_ok) state_d = ST_PIX;
      end
      ST_PIX: begin
        raw_valid = ser_valid;
        raw_dc    = 1'b1;
        raw_data  = ser_data;
        if (ser_take) rem_d = rem_q - 32'd1;
        // rem_q reaches zero once the final pixel is latched; its last byte ends the window.
        if (ser_last && rem_q == 32'd0) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      arg_idx_d = 2'd0;
      rem_d     = 32'd0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      arg_idx_q <= 2'd0;
      sx_q      <= 16'h0;
      sy_q      <= 16'h0;
      ec_q      <= 16'h0;
      ep_q      <= 16'h0;
      rem_q     <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arg_idx_q <= arg_idx_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      ec_q      <= ec_d;
      ep_q      <= ep_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
    end
  end

  assign out_valid = raw_valid && !abort;
  assign out_data  = raw_data;
  assign out_dc    = raw_dc;
  assign pix_ready = ser_in_ready;
  assign busy      = (state_q != ST_IDLE) || done_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ssd1963_win_seq.sv
// Directed testbench for ssd1963_win_seq: byte streams, stalls, wrap, empty window, abort, reset.
module tb_ssd1963_win_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] sx = 16'h0, sy = 16'h0, sw = 16'h0, sh = 16'h0;
  logic [23:0] pix_data;
  logic        pix_valid = 1'b1;
  logic        pix_ready;
  logic [7:0]  out_data;
  logic        out_dc;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [3:0]  dbg_state;

`ifdef SSD1963_SEQ_RGB565_EN
  localparam int BPP = 2;
`else
  localparam int BPP = 3;
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         n_done, n_valid, n_take, pix_i;
  logic       fixed_pix = 1'b0;
  logic       ready_mode = 1'b0;
  logic       tk = 1'b0;
  logic       stall_prev = 1'b0;
  logic [8:0] prev_byte = 9'h0;

  ssd1963_win_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .sx        (sx),
    .sy        (sy),
    .sw        (sw),
    .sh        (sh),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .out_data  (out_data),
    .out_dc    (out_dc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock and ready pattern
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = ready_mode ? ~out_ready : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel source: always valid, advances after each accepted pixel
  function automatic logic [23:0] pixval(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hA0 + b, 8'hB0 + b, 8'hC0 + b};
  endfunction

  always_comb pix_data = fixed_pix ? 24'hAB1234 : pixval(pix_i);

  always @(posedge clk) begin
    #1;
    if (tk) begin
      pix_i++;
      n_take++;
      tk = 1'b0;
    end
  end

  // Monitor: collects transferred bytes and checks stability during stalls
  always @(negedge clk) begin
    if (reset_n) begin
      tk = pix_valid && pix_ready;
      if (out_valid) n_valid++;
      if (done) n_done++;
      if (stall_prev && !abort) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_byte", 32'({out_dc, out_data}), 32'(prev_byte));
      end
      if (out_valid && out_ready) got_q.push_back({out_dc, out_data});
      stall_prev = out_valid && !out_ready;
      prev_byte  = {out_dc, out_data};
    end else begin
      stall_prev = 1'b0;
      tk = 1'b0;
    end
  end

  task automatic build_exp(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] w, input logic [15:0] h, input logic fx);
    logic [15:0] ec, ep;
    logic [23:0] px;
    exp_q.delete();
    if (w == 16'd0 || h == 16'd0) return;
    ec = x + w - 16'd1;
    ep = y + h - 16'd1;
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, x[15:8]});  exp_q.push_back({1'b1, x[7:0]});
    exp_q.push_back({1'b1, ec[15:8]}); exp_q.push_back({1'b1, ec[7:0]});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, y[15:8]});  exp_q.push_back({1'b1, y[7:0]});
    exp_q.push_back({1'b1, ep[15:8]}); exp_q.push_back({1'b1, ep[7:0]});
    exp_q.push_back({1'b0, 8'h2C});
    for (int p = 0; p < int'(w) * int'(h); p++) begin
      px = fx ? 24'hAB1234 : pixval(p);
      if (BPP == 3) exp_q.push_back({1'b1, px[23:16]});
      exp_q.push_back({1'b1, px[15:8]});
      exp_q.push_back({1'b1, px[7:0]});
    end
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic pulse_start(input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] w, input logic [15:0] h);
    got_q.delete();
    n_done = 0; n_valid = 0; n_take = 0; pix_i = 0;
    @(posedge clk); #1;
    sx = x; sy = y; sw = w; sh = h;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one window; c counts negedges after the accepting edge
  task automatic run_xfer(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] w, input logic [15:0] h, input int bound,
                          output int done_cyc, output logic v1, output logic [7:0] d1,
                          output logic b1, output logic bd, output logic ba);
    done_cyc = -1; v1 = 1'b0; d1 = 8'h0; b1 = 1'b0; bd = 1'b0; ba = 1'b1;
    pulse_start(x, y, w, h);
    for (int c = 0; c <= bound; c++) begin
      if (c > 0) @(negedge clk);
      else @(negedge clk);
      if (c == 0) begin v1 = out_valid; d1 = out_data; b1 = busy; end
      if (done && done_cyc < 0) begin done_cyc = c + 1; bd = busy; end
      else if (done_cyc > 0 && c + 1 == done_cyc + 1) ba = busy;
      if (done_cyc > 0 && c + 1 > done_cyc + 3) break;
    end
  endtask

  initial begin
    int dc;
    logic v1, b1, bd, ba;
    logic [7:0] d1;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_dc", 32'(out_dc), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic window with out_ready high
    run_xfer(16'd10, 16'd20, 16'd2, 16'd1, 200, dc, v1, d1, b1, bd, ba);
    build_exp(16'd10, 16'd20, 16'd2, 16'd1, 1'b0);
    cmp_stream("basic");
    chk("basic_first_valid", 32'(v1), 32'd1);
    chk("basic_first_data", 32'(d1), 32'h2A);
    chk("basic_first_busy", 32'(b1), 32'd1);
    chk("basic_done_cyc", 32'(dc), 32'(11 + 2 * BPP + 2));
    chk("basic_done_pulses", 32'(n_done), 32'd1);
    chk("basic_busy_at_done", 32'(bd), 32'd1);
    chk("basic_busy_after", 32'(ba), 32'd0);
    chk("basic_takes", 32'(n_take), 32'd2);

    // Same window with out_ready toggling
    ready_mode = 1'b1;
    run_xfer(16'd10, 16'd20, 16'd2, 16'd1, 400, dc, v1, d1, b1, bd, ba);
    cmp_stream("toggle");
    chk("toggle_done_pulses", 32'(n_done), 32'd1);
    chk("toggle_takes", 32'(n_take), 32'd2);
    ready_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Column end wraps modulo 2^16
    run_xfer(16'hFFFF, 16'd0, 16'd2, 16'd1, 200, dc, v1, d1, b1, bd, ba);
    build_exp(16'hFFFF, 16'd0, 16'd2, 16'd1, 1'b0);
    chk("wrap_ec_hi", 32'(exp_q[3]), 32'h100);
    cmp_stream("wrap");

    // Empty window: no bytes, done two cycles after start
    run_xfer(16'd5, 16'd5, 16'd0, 16'd3, 50, dc, v1, d1, b1, bd, ba);
    chk("empty_valid_cycles", 32'(n_valid), 32'd0);
    chk("empty_done_cyc", 32'(dc), 32'd2);
    chk("empty_busy_first", 32'(b1), 32'd1);
    chk("empty_done_pulses", 32'(n_done), 32'd1);
    chk("empty_takes", 32'(n_take), 32'd0);

    // Abort during the third pixel byte of a 4x4 window
    pulse_start(16'd1, 16'd2, 16'd4, 16'd4);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (got_q.size() >= 13) break;
    end
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    chk("abort_pix_ready", 32'(pix_ready), 32'd0);
    repeat (30) @(negedge clk);
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_bytes", 32'(got_q.size()), 32'd13);

    run_xfer(16'd1, 16'd2, 16'd4, 16'd4, 300, dc, v1, d1, b1, bd, ba);
    build_exp(16'd1, 16'd2, 16'd4, 16'd4, 1'b0);
    cmp_stream("post_abort");
    chk("post_abort_done_pulses", 32'(n_done), 32'd1);
    chk("post_abort_takes", 32'(n_take), 32'd16);

    // Reset asserted mid-PIX clears outputs immediately
    pulse_start(16'd1, 16'd2, 16'd4, 16'd4);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (got_q.size() >= 13) break;
    end
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'h00);
    chk("midrst_dc", 32'(out_dc), 32'd0);
    chk("midrst_pix_ready", 32'(pix_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // First start after reset, 1x1 window with a fixed pixel value
    fixed_pix = 1'b1;
    run_xfer(16'd3, 16'd4, 16'd1, 16'd1, 100, dc, v1, d1, b1, bd, ba);
    build_exp(16'd3, 16'd4, 16'd1, 16'd1, 1'b1);
    cmp_stream("one_pix");
    chk("one_pix_last", 32'(got_q.size() > 0 ? got_q[got_q.size() - 1] : 9'h0), 32'h134);
    chk("one_pix_done_cyc", 32'(dc), 32'(11 + BPP + 2));
    fixed_pix = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
